obs_misr: RTL

Downstream observation stage for the 3-bit `S` output bus of the sequential test circuits. It compacts a programmed number of consecutive `S` samples into a 16-bit multiple-input signature (MISR) and counts cycles with `S[0]` high, so a whole run can be checked against one golden signature. A START/DONE/ACK handshake controls the block; it is clocked on the same `CLK` as the circuit under test.

---
 rtl/obs_misr.sv | 99 +++++++++
 1 files changed

// File: rtl/obs_misr.sv
// Observation MISR: compacts LEN consecutive 3-bit S_IN samples into a 16-bit
// signature and counts samples with S_IN[0] high, under a START/DONE/ACK handshake.
module obs_misr #(
  parameter int               SIG_W = 16,
  parameter int               LEN_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       S_IN,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic [LEN_W-1:0] HITS
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [SIG_W-1:0] r_sig;
  logic [LEN_W-1:0] r_hits;
  logic [LEN_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;

  logic [SIG_W-1:0] w_sig_next;
  logic [LEN_W-1:0] w_hits_next;

  always_comb begin
    w_sig_next  = {r_sig[SIG_W-2:0], 1'b0}
                ^ (r_sig[SIG_W-1] ? POLY : '0)
                ^ {{(SIG_W-3){1'b0}}, S_IN};
    w_hits_next = r_hits + LEN_W'(S_IN[0]);
  end

  // BUSY/DONE are registered alongside the state so they track it exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sig   <= SEED;
      r_hits  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_sig  <= SEED;
            r_hits <= '0;
            r_rem  <= LEN;
            if (LEN != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_sig  <= w_sig_next;
          r_hits <= w_hits_next;
          r_rem  <= r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (ACK) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign SIG  = r_sig;
  assign HITS = r_hits;

endmodule
